// File: rtl/issue_queue_stage.sv
// issue_queue_stage
//   Issue stage in front of the two-stage ALU pipeline. Bundles of
//   {instruction, operand1, operand2} are accepted through a valid/ready
//   handshake into a circular FIFO of DEPTH entries. At most one bundle is
//   issued per clock. stall freezes the output registers. An empty FIFO
//   issues an all-zero bubble with out_valid low.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of issued_cnt
//
// Ports
//   clk, reset                        rising-edge clock, sync active-high reset
//   in_valid / in_ready               producer handshake (in_ready = count < DEPTH)
//   in_instruction, in_operand1/2     incoming bundle
//   stall                             downstream hold request
//   instruction, operand1/2           registered bundle to the pipeline
//   out_valid                         outputs carry a real bundle
//   count                             FIFO occupancy
//   issued_cnt                        bundles issued, wraps
//   drop_cnt                          bundles filtered by opcode, saturates
//
// Optional feature
//   ISSUE_OPCODE_FILTER_EN: when defined, handshaken bundles whose opcode
//   [3:0] is neither add (0000) nor sub (0001) are dropped and counted.
module issue_queue_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instruction,
  input  logic [31:0]            in_operand1,
  input  logic [31:0]            in_operand2,
  input  logic                   stall,
  output logic [31:0]            instruction,
  output logic [31:0]            operand1,
  output logic [31:0]            operand2,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic [7:0]             drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  logic [95:0]          mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_BITS-1:0]  count_r;
  logic [CNT_BITS-1:0]  count_next_s;
  logic                 in_ready_r;
  logic [31:0]          instruction_r;
  logic [31:0]          operand1_r;
  logic [31:0]          operand2_r;
  logic                 out_valid_r;
  logic [CNT_W-1:0]     issued_cnt_r;
  logic [7:0]           drop_cnt_r;
  logic                 push_s;
  logic                 write_s;
  logic                 pop_s;
  logic                 opcode_ok_s;

  // Handshake, pop decision and next occupancy.
  always_comb begin
    push_s = in_valid && in_ready_r;
    // A stalled stage never pops; the head only leaves when stall is low.
    pop_s  = !stall && (count_r != '0);
`ifdef ISSUE_OPCODE_FILTER_EN
    opcode_ok_s = (in_instruction[3:0] == 4'b0000) || (in_instruction[3:0] == 4'b0001);
`else
    opcode_ok_s = 1'b1;
`endif
    write_s = push_s && opcode_ok_s;
    case ({write_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_BITS'(1);
      2'b01:   count_next_s = count_r - CNT_BITS'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Bundle storage; data is not reset, only the pointers that index it.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= {in_instruction, in_operand1, in_operand2};
    end
  end

  // Pointers, occupancy and registered in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      in_ready_r <= 1'b1;
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      // Registered so in_ready never depends combinationally on stall.
      in_ready_r <= (count_next_s < CNT_BITS'(DEPTH));
    end
  end

  // Output registers: hold on stall, load head on pop, bubble when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_r <= 32'd0;
      operand1_r    <= 32'd0;
      operand2_r    <= 32'd0;
      out_valid_r   <= 1'b0;
      issued_cnt_r  <= '0;
    end else if (stall) begin
      instruction_r <= instruction_r;
      operand1_r    <= operand1_r;
      operand2_r    <= operand2_r;
      out_valid_r   <= out_valid_r;
    end else if (pop_s) begin
      {instruction_r, operand1_r, operand2_r} <= mem_r[rd_ptr_r];
      out_valid_r   <= 1'b1;
      issued_cnt_r  <= issued_cnt_r + CNT_W'(1);
    end else begin
      instruction_r <= 32'd0;
      operand1_r    <= 32'd0;
      operand2_r    <= 32'd0;
      out_valid_r   <= 1'b0;
    end
  end

`ifdef ISSUE_OPCODE_FILTER_EN
  // Count filtered bundles, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r <= 8'd0;
    end else if (push_s && !opcode_ok_s && (drop_cnt_r != 8'd255)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end
`else
  // No filtering in this build, so nothing is ever dropped.
  always_comb begin
    drop_cnt_r = 8'd0;
  end
`endif

  assign in_ready    = in_ready_r;
  assign instruction = instruction_r;
  assign operand1    = operand1_r;
  assign operand2    = operand2_r;
  assign out_valid   = out_valid_r;
  assign count       = count_r;
  assign issued_cnt  = issued_cnt_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_issue_queue_stage.sv
module tb_issue_queue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instruction, in_operand1, in_operand2;
  logic        stall;

  logic        in_ready, out_valid;
  logic [31:0] instruction, operand1, operand2;
  logic [2:0]  count;
  logic [15:0] issued_cnt;
  logic [7:0]  drop_cnt;

  logic        w_in_ready, w_out_valid;
  logic [31:0] w_instruction, w_operand1, w_operand2;
  logic [2:0]  w_count;
  logic [3:0]  w_issued_cnt;
  logic [7:0]  w_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_queue_stage #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_operand1(in_operand1), .in_operand2(in_operand2),
    .stall(stall), .instruction(instruction), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .count(count), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt)
  );

  // Narrow issued_cnt instance driven by the same stimulus, for the wrap case.
  issue_queue_stage #(.DEPTH(4), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instruction(in_instruction), .in_operand1(in_operand1), .in_operand2(in_operand2),
    .stall(stall), .instruction(w_instruction), .operand1(w_operand1), .operand2(w_operand2),
    .out_valid(w_out_valid), .count(w_count), .issued_cnt(w_issued_cnt), .drop_cnt(w_drop_cnt)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] i,
                            input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] c);
    check_value({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check_value({tag, ".instr"}, instruction, i);
    check_value({tag, ".op1"}, operand1, o1);
    check_value({tag, ".op2"}, operand2, o2);
    check_value({tag, ".count"}, {29'd0, count}, c);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] o1, input logic [31:0] o2);
    in_valid = v;
    in_instruction = i;
    in_operand1 = o1;
    in_operand2 = o2;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #2;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    expect_out("rst", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    check_value("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check_value("rst.issued", {16'd0, issued_cnt}, 32'd0);
    check_value("rst.drop", {24'd0, drop_cnt}, 32'd0);

    // Single bundle latency
    drive(1'b1, 32'd0, 32'd5, 32'd3);
    tick();
    expect_out("lat.n", 1'b0, 32'd0, 32'd0, 32'd0, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    expect_out("lat.n1", 1'b1, 32'd0, 32'd5, 32'd3, 32'd0);
    tick();
    expect_out("lat.n2", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    check_value("lat.issued", {16'd0, issued_cnt}, 32'd1);

    // Fill under stall, fifth bundle held back by producer
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'd1, 32'd100 + k, 32'd200 + k);
      tick();
    end
    expect_out("full", 1'b0, 32'd0, 32'd0, 32'd0, 32'd4);
    check_value("full.in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'd1, 32'd104, 32'd204);
    tick();
    check_value("full.held_count", {29'd0, count}, 32'd4);
    stall = 1'b0;
    tick();
    expect_out("drain0", 1'b1, 32'd1, 32'd100, 32'd200, 32'd3);
    check_value("drain0.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    expect_out("drain1", 1'b1, 32'd1, 32'd101, 32'd201, 32'd3);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    expect_out("drain2", 1'b1, 32'd1, 32'd102, 32'd202, 32'd2);
    tick();
    expect_out("drain3", 1'b1, 32'd1, 32'd103, 32'd203, 32'd1);
    tick();
    expect_out("drain4", 1'b1, 32'd1, 32'd104, 32'd204, 32'd0);
    tick();
    expect_out("drain.bubble", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    check_value("drain.issued", {16'd0, issued_cnt}, 32'd6);

    // Alternating stall with streaming input
    drive(1'b1, 32'd1, 32'd10, 32'd4);
    tick();
    expect_out("alt1", 1'b0, 32'd0, 32'd0, 32'd0, 32'd1);
    stall = 1'b1;
    drive(1'b1, 32'd0, 32'd20, 32'd7);
    tick();
    expect_out("alt2", 1'b0, 32'd0, 32'd0, 32'd0, 32'd2);
    stall = 1'b0;
    drive(1'b1, 32'd1, 32'd30, 32'd9);
    tick();
    expect_out("alt3", 1'b1, 32'd1, 32'd10, 32'd4, 32'd2);
    stall = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    expect_out("alt4", 1'b1, 32'd1, 32'd10, 32'd4, 32'd2);
    stall = 1'b0;
    tick();
    expect_out("alt5", 1'b1, 32'd0, 32'd20, 32'd7, 32'd1);
    stall = 1'b1;
    tick();
    expect_out("alt6", 1'b1, 32'd0, 32'd20, 32'd7, 32'd1);
    stall = 1'b0;
    tick();
    expect_out("alt7", 1'b1, 32'd1, 32'd30, 32'd9, 32'd0);
    tick();
    expect_out("alt8", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    check_value("alt.issued", {16'd0, issued_cnt}, 32'd9);

    // Opcode outside add/sub
    drive(1'b1, 32'd2, 32'd77, 32'd88);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    check_value("filt.in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ISSUE_OPCODE_FILTER_EN
    check_value("filt.count", {29'd0, count}, 32'd0);
    check_value("filt.drop", {24'd0, drop_cnt}, 32'd1);
    tick();
    expect_out("filt.out", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
`else
    check_value("filt.count", {29'd0, count}, 32'd1);
    check_value("filt.drop", {24'd0, drop_cnt}, 32'd0);
    tick();
    expect_out("filt.out", 1'b1, 32'd2, 32'd77, 32'd88, 32'd0);
`endif
    tick();

    // Reset mid-stream discards queue and held output
    drive(1'b1, 32'd1, 32'd51, 32'd1);
    tick();
    drive(1'b1, 32'd1, 32'd52, 32'd2);
    tick();
    stall = 1'b1;
    drive(1'b1, 32'd1, 32'd53, 32'd3);
    tick();
    drive(1'b1, 32'd1, 32'd54, 32'd4);
    tick();
    expect_out("mid.pre", 1'b1, 32'd1, 32'd51, 32'd1, 32'd3);
    reset = 1'b1;
    stall = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    reset = 1'b0;
    expect_out("mid.rst", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    check_value("mid.in_ready", {31'd0, in_ready}, 32'd1);
    check_value("mid.issued", {16'd0, issued_cnt}, 32'd0);
    tick();
    tick();
    expect_out("mid.after", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

    // issued_cnt wrap on the 4-bit instance
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 32'd0, 32'd300 + k, 32'd0);
      tick();
    end
    check_value("wrap.15", {28'd0, w_issued_cnt}, 32'd15);
    drive(1'b1, 32'd0, 32'd316, 32'd0);
    tick();
    check_value("wrap.0", {28'd0, w_issued_cnt}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    check_value("wrap.1", {28'd0, w_issued_cnt}, 32'd1);
    check_value("wrap.wide", {16'd0, issued_cnt}, 32'd17);
    check_value("wrap.last_op1", operand1, 32'd316);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue_stage.md
# issue_queue_stage

Upstream issue stage for the two-stage ALU pipeline. Buffers {instruction, operand1, operand2} bundles from a producer through a valid/ready handshake in a small circular FIFO. Issues at most one bundle per clock onto the pipeline's instruction/operand1/operand2 inputs, with a stall input that freezes issue. Inserts an all-zero bubble when the FIFO is empty.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of issued_cnt

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a bundle
- in_ready  out  1  FIFO can accept; high when count < DEPTH
- in_instruction  in  32  opcode in [3:0]: 0000 add, 0001 sub
- in_operand1  in  32  first operand
- in_operand2  in  32  second operand
- stall  in  1  downstream hold request
- instruction  out  32  registered, to pipeline
- operand1  out  32  registered, to pipeline
- operand2  out  32  registered, to pipeline
- out_valid  out  1  outputs carry a real bundle this cycle
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- issued_cnt  out  CNT_W  bundles issued, wraps modulo 2^CNT_W
- drop_cnt  out  8  bundles filtered (see Configuration)

## Operation
- Storage: DEPTH × 96-bit array; wr_ptr, rd_ptr of $clog2(DEPTH) bits; both wrap DEPTH-1 → 0.
- in_ready = (count < DEPTH). Decoded from registered count only; no combinational path from stall or the pop decision.
- Push: in_valid && in_ready. Write at wr_ptr, then increment wr_ptr.
- Issue decision, evaluated each edge, in priority order:
  - stall=1: instruction, operand1, operand2 and out_valid all hold. No pop.
  - stall=0, count>0: load head into output registers, out_valid←1, rd_ptr++, issued_cnt++.
  - stall=0, count=0: bubble. instruction, operand1, operand2 ← 0 and out_valid←0.
- count update: +1 on push only; −1 on pop only; unchanged on simultaneous push and pop, or on neither.
- Full: in_ready=0, so no push even if a pop occurs the same cycle. in_ready rises the cycle after the pop.
- No write-through: a bundle pushed into an empty FIFO is never issued in the same edge.

## Timing
- Reset (synchronous, checked at each edge, dominates all other activity): wr_ptr, rd_ptr, count ← 0. instruction, operand1, operand2 ← 0. out_valid, issued_cnt, drop_cnt ← 0. in_ready=1 the following cycle.
- Reset mid-operation discards all queued bundles and any held stalled output.
- Latency, empty FIFO, no stall: push accepted at edge N appears on the outputs with out_valid=1 after edge N+1.
- Throughput: one issue per cycle while count>0 and stall=0. Continuous push plus continuous issue keeps count constant.
- stall asserted for K cycles: the output is held for K edges, and the next head issues at the first edge with stall=0.
- issued_cnt wraps from 2^CNT_W−1 to 0.

## Configuration
- Macro: ISSUE_OPCODE_FILTER_EN.
- Defined:
  - A handshaken bundle whose in_instruction[3:0] is not 0000 or 0001 completes the handshake but is not written. wr_ptr and count are unchanged.
  - drop_cnt increments and saturates at 255.
- Undefined: every handshaken bundle is written; drop_cnt is tied to 0.

## Test plan
- Reset, then push one bundle (instr=0, op1=5, op2=3) at edge N → after edge N+1: instruction=0, operand1=5, operand2=3, out_valid=1. After N+2: bubble of zeros with out_valid=0; issued_cnt=1.
- Hold stall=1 and push 5 bundles, DEPTH=4 → first 4 accepted, count=4, in_ready=0, 5th held by producer. Release stall → issues the 4 in order on consecutive cycles, then the 5th.
- Continuous in_valid plus alternating stall, entries (instr=1, op1=10, op2=4) and others → output order matches push order, no loss or duplication, and outputs hold exactly on stall cycles.
- Fill to count=3, then assert reset for one edge mid-stream → next cycle count=0, out_valid=0, all outputs 0, in_ready=1, and old bundles never issue.
- With ISSUE_OPCODE_FILTER_EN, push instr[3:0]=0010 → in_ready stays 1, count unchanged, drop_cnt=1, nothing issued. Without the macro the bundle issues and drop_cnt=0.
- Force issued_cnt near 2^CNT_W−1 (CNT_W=4 build) and issue 2 bundles → value goes 15 → 0 → 1.
